stg_if: RTL and testbench

STG_IF -- requirements
Module: stg_if

---
 rtl/stg_if_pkg.sv | 21 ++
 rtl/stg_if_fifo.sv | 59 +++++
 rtl/stg_if.sv | 135 +++++++++++++
 tb/tb_stg_if.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stg_if_pkg.sv
// Shared sizes for the fetch stage; STG_IF_PREFETCH_EN selects a 2-deep
// prefetch buffer, otherwise a single-entry buffer.
package stg_if_pkg;

    localparam int SIZE_ADDR = 16;
    localparam int SIZE_DATA = 32;

`ifdef STG_IF_PREFETCH_EN
    localparam int IF_FIFO_DEPTH = 2;
`else
    localparam int IF_FIFO_DEPTH = 1;
`endif

    localparam int IF_CNT_W = $clog2(IF_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [SIZE_ADDR-1:0] pc;
        logic [SIZE_DATA-1:0] instr;
    } if_entry_t;

endpackage

// File: rtl/stg_if_fifo.sv
// Small circular FIFO holding fetched {pc, instr} pairs; synchronous clear
// empties it in one cycle and takes priority over push/pop.
module stg_if_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             iw_clk,
    input  logic             iw_rst,
    input  logic             iw_push,
    input  logic [WIDTH-1:0] iw_data,
    input  logic             iw_pop,
    input  logic             iw_clear,
    output logic [WIDTH-1:0] ow_head,
    output logic [CNT_W-1:0] ow_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_pop  = iw_pop && (r_count != '0);
    assign w_do_push = iw_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (iw_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // NOTE: storage has no reset; the count guards every read, so stale contents are never consumed.
    always_ff @(posedge iw_clk) begin
        if (w_do_push && !iw_clear) r_mem[r_wr_ptr] <= iw_data;
    end

    assign ow_head  = r_mem[r_rd_ptr];
    assign ow_count = r_count;

endmodule

// File: rtl/stg_if.sv
// Instruction-fetch stage: one outstanding imem request, prefetch buffer, ID output latch.
// Define STG_IF_PREFETCH_EN for back-to-back fetch into a 2-deep buffer.
module stg_if
    import stg_if_pkg::*;
(
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_redirect,
    input  logic [SIZE_ADDR-1:0] iw_redirect_pc,
    input  logic                 iw_stall,
    output logic                 ow_imem_req,
    output logic [SIZE_ADDR-1:0] ow_imem_addr,
    input  logic                 iw_imem_ack,
    input  logic [SIZE_DATA-1:0] iw_imem_data,
    output logic [SIZE_ADDR-1:0] ow_pc,
    output logic [SIZE_DATA-1:0] ow_instr,
    output logic                 ow_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } state_t;

    localparam int LVL_W = IF_CNT_W + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SIZE_ADDR-1:0] r_fpc;
    logic [SIZE_ADDR-1:0] r_req_pc;
    logic                 r_outstanding;
    logic                 w_ack_hit;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_slot_ok;
    logic                 w_issue;
    logic [LVL_W-1:0]     w_level;
    logic [IF_CNT_W-1:0]  w_fifo_count;
    if_entry_t            w_fifo_in;
    if_entry_t            w_fifo_head;

    // Only acks for a live request in RUN are kept; DRAIN means the outstanding one is stale.
    assign w_ack_hit = iw_imem_ack && r_outstanding;
    assign w_push    = w_ack_hit && (r_state == S_RUN) && !iw_redirect;
    assign w_pop     = !iw_stall && !iw_redirect && (w_fifo_count != '0);

    assign w_level = LVL_W'(w_fifo_count)
                   + LVL_W'(r_outstanding && !iw_imem_ack)
                   + LVL_W'(w_push)
                   - LVL_W'(w_pop);

`ifdef STG_IF_PREFETCH_EN
    assign w_slot_ok = !r_outstanding || w_ack_hit;
`else
    assign w_slot_ok = !r_outstanding && !iw_imem_ack;
`endif

    assign w_issue = (r_state == S_RUN) && !iw_redirect && w_slot_ok
                  && (w_level < LVL_W'(IF_FIFO_DEPTH));

    assign ow_imem_req  = w_issue;
    assign ow_imem_addr = w_issue ? r_fpc : '0;

    // NOTE: next-state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_RUN;
            S_RUN:   if (iw_redirect && r_outstanding && !iw_imem_ack) w_state_nxt = S_DRAIN;
            S_DRAIN: if (iw_imem_ack) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state       <= S_IDLE;
            r_fpc         <= '0;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (iw_redirect)  r_fpc <= iw_redirect_pc;
            else if (w_issue) r_fpc <= r_fpc + SIZE_ADDR'(1);
            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fpc;
            end else if (iw_imem_ack) begin
                r_outstanding <= 1'b0;
            end
        end
    end

    assign w_fifo_in = '{pc: r_req_pc, instr: iw_imem_data};

    stg_if_fifo #(
        .DEPTH (IF_FIFO_DEPTH),
        .WIDTH ($bits(if_entry_t))
    ) u_fifo (
        .iw_clk   (iw_clk),
        .iw_rst   (iw_rst),
        .iw_push  (w_push),
        .iw_data  (w_fifo_in),
        .iw_pop   (w_pop),
        .iw_clear (iw_redirect),
        .ow_head  (w_fifo_head),
        .ow_count (w_fifo_count)
    );

    // Redirect forces a bubble even under stall so ID never sees the old stream.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ow_pc    <= '0;
            ow_instr <= '0;
            ow_valid <= 1'b0;
        end else if (iw_redirect || !iw_stall) begin
            if (w_pop) begin
                ow_pc    <= w_fifo_head.pc;
                ow_instr <= w_fifo_head.instr;
                ow_valid <= 1'b1;
            end else begin
                ow_pc    <= '0;
                ow_instr <= '0;
                ow_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stg_if.sv
// Directed bench for stg_if with a latency-programmable memory returning instr = addr + 0x100.
// Expectations follow the build's STG_IF_PREFETCH_EN setting.
`timescale 1ns/1ps
module tb_stg_if;
    import stg_if_pkg::*;

    logic                 iw_clk = 1'b0;
    logic                 iw_rst;
    logic                 iw_redirect;
    logic [SIZE_ADDR-1:0] iw_redirect_pc;
    logic                 iw_stall;
    logic                 ow_imem_req;
    logic [SIZE_ADDR-1:0] ow_imem_addr;
    logic                 iw_imem_ack;
    logic [SIZE_DATA-1:0] iw_imem_data;
    logic [SIZE_ADDR-1:0] ow_pc;
    logic [SIZE_DATA-1:0] ow_instr;
    logic                 ow_valid;

    stg_if dut (
        .iw_clk         (iw_clk),
        .iw_rst         (iw_rst),
        .iw_redirect    (iw_redirect),
        .iw_redirect_pc (iw_redirect_pc),
        .iw_stall       (iw_stall),
        .ow_imem_req    (ow_imem_req),
        .ow_imem_addr   (ow_imem_addr),
        .iw_imem_ack    (iw_imem_ack),
        .iw_imem_data   (iw_imem_data),
        .ow_pc          (ow_pc),
        .ow_instr       (ow_instr),
        .ow_valid       (ow_valid)
    );

    always #5 iw_clk = ~iw_clk;

    int                   n_tests = 0;
    int                   n_fail  = 0;
    int                   mem_lat;
    int                   mem_left;
    logic                 mem_busy;
    logic [SIZE_ADDR-1:0] mem_addr;
    logic [SIZE_ADDR-1:0] req_log [$];
    int                   n0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [SIZE_ADDR-1:0] pc,
                             input logic [SIZE_DATA-1:0] instr);
        check({tag, ".valid"}, 64'(ow_valid), 64'(v));
        check({tag, ".pc"},    64'(ow_pc),    64'(pc));
        check({tag, ".instr"}, 64'(ow_instr), 64'(instr));
    endtask

    // One clock: apply this cycle's inputs, serve memory, then log any request.
    task automatic cycle(input logic stall = 1'b0, input logic redir = 1'b0,
                         input logic [SIZE_ADDR-1:0] rpc = '0);
        @(posedge iw_clk);
        #1;
        iw_stall       = stall;
        iw_redirect    = redir;
        iw_redirect_pc = rpc;
        iw_imem_ack    = 1'b0;
        iw_imem_data   = '0;
        if (mem_busy) begin
            if (mem_left <= 1) begin
                iw_imem_ack  = 1'b1;
                iw_imem_data = 32'(mem_addr) + 32'h100;
                mem_busy     = 1'b0;
            end else begin
                mem_left--;
            end
        end
        #1;
        if (ow_imem_req) begin
            req_log.push_back(ow_imem_addr);
            mem_busy = 1'b1;
            mem_left = mem_lat;
            mem_addr = ow_imem_addr;
        end
    endtask

    // Release lands mid-cycle 0 (FSM in IDLE); junk optionally injects a stray ack there.
    task automatic do_reset(input int lat, input logic junk);
        iw_rst         = 1'b1;
        iw_stall       = 1'b0;
        iw_redirect    = 1'b0;
        iw_redirect_pc = '0;
        iw_imem_ack    = 1'b0;
        iw_imem_data   = '0;
        mem_busy       = 1'b0;
        mem_left       = 0;
        mem_addr       = '0;
        mem_lat        = lat;
        req_log.delete();
        @(posedge iw_clk);
        @(posedge iw_clk);
        #1;
        iw_rst = 1'b0;
        if (junk) begin
            iw_imem_ack  = 1'b1;
            iw_imem_data = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    initial begin
        // Reset state and free-run at 1-cycle latency, stray ack while IDLE.
        do_reset(1, 1'b1);
        check_out("rst", 1'b0, '0, '0);
        check("rst.req",  64'(ow_imem_req),  64'(0));
        check("rst.addr", 64'(ow_imem_addr), 64'(0));
        cycle();
        check("run.first_req", 64'(req_log[0]), 64'(0));
        check_out("run.c1", 1'b0, '0, '0);
        cycle(); check_out("run.c2", 1'b0, '0, '0);
        cycle(); check_out("run.c3", 1'b0, '0, '0);
`ifdef STG_IF_PREFETCH_EN
        cycle(); check_out("pf.c4", 1'b1, 16'd0, 32'h100);
        cycle(); check_out("pf.c5", 1'b1, 16'd1, 32'h101);
        n0 = req_log.size();
        cycle(1'b1); check_out("pf.stall_a", 1'b1, 16'd2, 32'h102);
        cycle(1'b1); check_out("pf.stall_b", 1'b1, 16'd2, 32'h102);
        cycle(1'b1); check_out("pf.stall_c", 1'b1, 16'd2, 32'h102);
        check("pf.stall_reqs_le2", 64'((req_log.size() - n0) <= 2), 64'(1));
        cycle(); check_out("pf.release", 1'b1, 16'd2, 32'h102);
        cycle(); check_out("pf.after_a", 1'b1, 16'd3, 32'h103);
        cycle(); check_out("pf.after_b", 1'b1, 16'd4, 32'h104);
`else
        cycle(); check_out("np.c4", 1'b1, 16'd0, 32'h100);
        cycle(); check_out("np.c5", 1'b0, '0, '0);
        cycle(); check_out("np.c6", 1'b1, 16'd1, 32'h101);
        cycle(); check_out("np.c7", 1'b0, '0, '0);
        n0 = req_log.size();
        cycle(1'b1); check_out("np.stall_a", 1'b1, 16'd2, 32'h102);
        cycle(1'b1); check_out("np.stall_b", 1'b1, 16'd2, 32'h102);
        check("np.stall_reqs", 64'(req_log.size() - n0), 64'(0));
        cycle(); check_out("np.release", 1'b1, 16'd2, 32'h102);
        cycle(); check_out("np.after", 1'b1, 16'd3, 32'h103);
`endif

        // Reset mid-transaction drops the request; stale ack after release is ignored.
        do_reset(3, 1'b0);
        cycle();
        check("mid.req_before", 64'(ow_imem_req), 64'(1));
        #1 iw_rst = 1'b1;
        #1;
        check("mid.req_in_rst",  64'(ow_imem_req),  64'(0));
        check("mid.addr_in_rst", 64'(ow_imem_addr), 64'(0));
        check("mid.valid_in_rst", 64'(ow_valid),    64'(0));

        // Redirect with a request outstanding (3-cycle memory), second redirect during DRAIN.
        do_reset(3, 1'b1);
        cycle();
        check("drain.req0", 64'(req_log[0]), 64'(0));
        check_out("drain.c1", 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 16'h0030); check_out("drain.c2", 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 16'h0040); check_out("drain.c3", 1'b0, '0, '0);
        cycle();
        check("drain.no_req", 64'(req_log.size()), 64'(1));
        check_out("drain.c4", 1'b0, '0, '0);
        cycle();
        check("drain.req_cnt", 64'(req_log.size()), 64'(2));
        check("drain.new_addr", 64'(req_log[1]), 64'(16'h0040));
        for (int k = 6; k <= 9; k++) begin
            cycle();
            check("drain.no_old", 64'(ow_valid), 64'(0));
        end
        cycle(); check_out("drain.first_new", 1'b1, 16'h0040, 32'h140);

        // Redirect coincident with an ack while ID stalls.
        do_reset(1, 1'b0);
        cycle(); cycle(); cycle();
        n0 = req_log.size();
        cycle(1'b1, 1'b1, 16'h0080);
        check_out("coinc.c4", 1'b1, 16'd0, 32'h100);
        check("coinc.no_issue", 64'(req_log.size() - n0), 64'(0));
        cycle(1'b1);
        check_out("coinc.bubble", 1'b0, '0, '0);
        check("coinc.issue_cnt", 64'(req_log.size() - n0), 64'(1));
        check("coinc.addr", 64'(req_log[req_log.size() - 1]), 64'(16'h0080));
        cycle(); check("coinc.c6", 64'(ow_valid), 64'(0));
        cycle(); check("coinc.c7", 64'(ow_valid), 64'(0));
        cycle(); check_out("coinc.first_new", 1'b1, 16'h0080, 32'h180);

        // Fetch PC wraps from all-ones to zero.
        do_reset(1, 1'b0);
        cycle();
        cycle(1'b0, 1'b1, 16'hFFFF);
        cycle(); cycle(); cycle();
        check("wrap.top", 64'(req_log[1]), 64'(16'hFFFF));
        check("wrap.zero", 64'(req_log[2]), 64'(0));
        cycle(); check_out("wrap.deliver", 1'b1, 16'hFFFF, 32'h100FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
